// File: rtl/ppu_pkg.sv
// Shared PPU definitions: sprite evaluation FSM states, OAM geometry and byte offsets.
package ppu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_READ_Y,
        ST_CHECK_Y,
        ST_COPY1,
        ST_COPY2,
        ST_COPY3,
        ST_DONE
    } eval_state_t;

    localparam int OAM_ENTRIES   = 64;
    localparam int SPRITE_SLOTS  = 8;
    localparam int SEC_OAM_BYTES = 4 * SPRITE_SLOTS;
    localparam int SPR_H8        = 8;
    localparam int SPR_H16       = 16;

    localparam logic [7:0] Y_HIDE = 8'hEF;

    localparam logic [1:0] OFS_Y    = 2'd0;
    localparam logic [1:0] OFS_TILE = 2'd1;
    localparam logic [1:0] OFS_ATTR = 2'd2;
    localparam logic [1:0] OFS_X    = 2'd3;

endpackage

// File: rtl/sprite_range_cmp.sv
// Sprite vertical range test: is the scanline inside the sprite, and which row of it.
module sprite_range_cmp
    import ppu_pkg::*;
(
    input  logic [7:0] scanline,
    input  logic [7:0] y,
    input  logic       sprite_size,
    output logic       in_range,
    output logic [3:0] row
);

    logic [8:0] d;
    logic [4:0] height;

    // d[8] is the borrow: scanline above the sprite top
    assign d        = {1'b0, scanline} - {1'b0, y};
    assign height   = sprite_size ? 5'(SPR_H16) : 5'(SPR_H8);
    assign in_range = (y < Y_HIDE) && !d[8] && (d[7:0] < {3'b000, height});
    assign row      = d[3:0];

endmodule

// File: rtl/sprite_evaluator.sv
// Per-scanline sprite evaluation: clears secondary OAM, then copies up to
// SPRITE_SLOTS in-range sprites from primary OAM and flags overflow.
module sprite_evaluator
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       eval_start,
    input  logic [7:0] scanline,
    input  logic       sprite_size,
    output logic [7:0] oam_addr,
    input  logic [7:0] oam_din,
    output logic       sec_we,
    output logic [4:0] sec_addr,
    output logic [7:0] sec_dout,
    output logic       busy,
    output logic       eval_done,
    output logic [3:0] sprite_count,
    output logic       sprite0_in_line,
    output logic       sprite_overflow,
    input  logic       ovf_clr
);

    eval_state_t state, state_nx;

    logic [5:0] n;
    logic [3:0] k;
    logic [4:0] clr_idx;
    logic       size_q;
    logic       in_range;
    logic [3:0] row_unused;
    logic       n_last;
    logic       slots_full;
    logic       copy_hit;
    logic       ovf_hit;

    sprite_range_cmp u_range_cmp (
        .scanline    (scanline),
        .y           (oam_din),
        .sprite_size (size_q),
        .in_range    (in_range),
        .row         (row_unused)
    );

    assign n_last     = (n == 6'(OAM_ENTRIES - 1));
    assign slots_full = (k == 4'(SPRITE_SLOTS));
    assign copy_hit   = (state == ST_CHECK_Y) && in_range && !slots_full;
    assign ovf_hit    = (state == ST_CHECK_Y) && in_range && slots_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            n               <= '0;
            k               <= '0;
            clr_idx         <= '0;
            size_q          <= 1'b0;
            sprite0_in_line <= 1'b0;
            sprite_overflow <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (eval_start) begin
                        n               <= '0;
                        k               <= '0;
                        clr_idx         <= '0;
                        sprite0_in_line <= 1'b0;
                        size_q          <= sprite_size;
                    end
                end
                ST_CLEAR: clr_idx <= clr_idx + 5'd1;
                ST_CHECK_Y: begin
                    if (copy_hit && (n == 6'd0))
                        sprite0_in_line <= 1'b1;
                    if (!in_range && !n_last)
                        n <= n + 6'd1;
                end
                ST_COPY3: begin
                    k <= k + 4'd1;
                    if (!n_last)
                        n <= n + 6'd1;
                end
                default: ;
            endcase
            // a fresh overflow beats a simultaneous clear
            if (ovf_hit)
                sprite_overflow <= 1'b1;
            else if (ovf_clr)
                sprite_overflow <= 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (eval_start) state_nx = ST_CLEAR;
            ST_CLEAR:   if (clr_idx == 5'(SEC_OAM_BYTES - 1)) state_nx = ST_READ_Y;
            ST_READ_Y:  state_nx = ST_CHECK_Y;
            ST_CHECK_Y: begin
                if (copy_hit)
                    state_nx = ST_COPY1;
                else if (ovf_hit || n_last)
                    state_nx = ST_DONE;
                else
                    state_nx = ST_READ_Y;
            end
            ST_COPY1:   state_nx = ST_COPY2;
            ST_COPY2:   state_nx = ST_COPY3;
            ST_COPY3:   state_nx = n_last ? ST_DONE : ST_READ_Y;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // oam_din is one cycle behind oam_addr, so each copy cycle writes the byte
    // requested in the previous cycle and requests the next one
    always_comb begin
        oam_addr = '0;
        sec_we   = 1'b0;
        sec_addr = '0;
        sec_dout = '0;
        case (state)
            ST_CLEAR: begin
                sec_we   = 1'b1;
                sec_addr = clr_idx;
                sec_dout = 8'hFF;
            end
            ST_READ_Y: oam_addr = {n, OFS_Y};
            ST_CHECK_Y: begin
                if (copy_hit) begin
                    sec_we   = 1'b1;
                    sec_addr = {k[2:0], OFS_Y};
                    sec_dout = oam_din;
                    oam_addr = {n, OFS_TILE};
                end
            end
            ST_COPY1: begin
                sec_we   = 1'b1;
                sec_addr = {k[2:0], OFS_TILE};
                sec_dout = oam_din;
                oam_addr = {n, OFS_ATTR};
            end
            ST_COPY2: begin
                sec_we   = 1'b1;
                sec_addr = {k[2:0], OFS_ATTR};
                sec_dout = oam_din;
                oam_addr = {n, OFS_X};
            end
            ST_COPY3: begin
                sec_we   = 1'b1;
                sec_addr = {k[2:0], OFS_X};
                sec_dout = oam_din;
            end
            default: ;
        endcase
    end

    assign busy         = (state != ST_IDLE);
    assign eval_done    = (state == ST_DONE);
    assign sprite_count = k;

endmodule

// File: tb/tb_sprite_evaluator.sv
// Scoreboard bench for sprite_evaluator: list-based reference model, monitor checks at eval_done.
module tb_sprite_evaluator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       eval_start = 1'b0;
    logic [7:0] scanline = 8'd0;
    logic       sprite_size = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] oam_addr;
    logic [7:0] oam_din = 8'd0;
    logic       sec_we;
    logic [4:0] sec_addr;
    logic [7:0] sec_dout;
    logic       busy, eval_done, sprite0_in_line, sprite_overflow;
    logic [3:0] sprite_count;

    sprite_evaluator dut (
        .clk(clk), .rst(rst), .eval_start(eval_start), .scanline(scanline),
        .sprite_size(sprite_size), .oam_addr(oam_addr), .oam_din(oam_din),
        .sec_we(sec_we), .sec_addr(sec_addr), .sec_dout(sec_dout), .busy(busy),
        .eval_done(eval_done), .sprite_count(sprite_count),
        .sprite0_in_line(sprite0_in_line), .sprite_overflow(sprite_overflow),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    logic [7:0] oam [256];
    logic [7:0] secm [32];

    always @(posedge clk) oam_din <= oam[oam_addr];
    always @(posedge clk) if (sec_we) secm[sec_addr] <= sec_dout;

    typedef struct {
        int           cnt;
        int           s0;
        int           ovf;
        int           lat;
        logic [255:0] sec;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    bit   ovf_model = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: walk OAM entries, collect the in-range list, charge cycles per entry
    task automatic model(input logic [7:0] sl, input bit sz, output exp_t e, output bit det);
        int hits[$];
        int h, cost, s, y;
        bit inr;
        h = sz ? 16 : 8;
        s = int'(sl);
        cost = 0;
        det = 1'b0;
        for (int n = 0; n < 64; n++) begin
            y = int'(oam[4*n]);
            inr = (y < 239) && (s >= y) && (s - y < h);
            if (inr && hits.size() == 8) begin
                det = 1'b1;
                cost += 2;
                break;
            end else if (inr) begin
                hits.push_back(n);
                cost += 5;
            end else begin
                cost += 2;
            end
        end
        e.cnt = hits.size();
        e.s0  = (hits.size() > 0 && hits[0] == 0) ? 1 : 0;
        e.ovf = (ovf_model || det) ? 1 : 0;
        e.lat = 1 + 32 + cost + 1;
        e.sec = '1;
        for (int i = 0; i < hits.size(); i++)
            for (int j = 0; j < 4; j++)
                e.sec[8*(4*i+j) +: 8] = oam[4*hits[i]+j];
    endtask

    exp_t         mon_e;
    logic [255:0] mon_got;

    always @(negedge clk) begin
        if (!rst && eval_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                for (int i = 0; i < 32; i++) mon_got[8*i +: 8] = secm[i];
                chk("sprite_count", sprite_count, mon_e.cnt);
                chk("sprite0_in_line", sprite0_in_line, mon_e.s0);
                chk("sprite_overflow", sprite_overflow, mon_e.ovf);
                chk("done_latency", cyc - start_cyc + 1, mon_e.lat);
                chk("secondary_oam", mon_got, mon_e.sec);
            end
        end
    end

    // dup_at: cycle to re-pulse eval_start (0 none, -1 the DONE cycle)
    task automatic run_eval(input logic [7:0] sl, input bit sz, input bit clr_on_det, input int dup_at);
        exp_t e;
        bit   det, done;
        int   clr_at, dup;
        model(sl, sz, e, det);
        clr_at = (clr_on_det && det) ? e.lat - 1 : 0;
        dup = (dup_at < 0) ? e.lat : dup_at;
        sb.push_back(e);
        @(negedge clk);
        scanline = sl;
        sprite_size = sz;
        eval_start = 1'b1;
        start_cyc = cyc;
        done = 1'b0;
        for (int c = 2; c <= 400; c++) begin
            @(negedge clk);
            eval_start = (c == dup);
            ovf_clr = (c == clr_at);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        eval_start = 1'b0;
        ovf_clr = 1'b0;
        if (!done) begin
            chk("eval_timeout", 1, 0);
            sb.delete();
        end
        chk("scoreboard_drain", sb.size(), 0);
        ovf_model = (e.ovf != 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_eval_done"}, eval_done, 0);
        chk({tag, "_sec_we"}, sec_we, 0);
        chk({tag, "_sec_addr"}, sec_addr, 0);
        chk({tag, "_sec_dout"}, sec_dout, 0);
        chk({tag, "_oam_addr"}, oam_addr, 0);
        chk({tag, "_count"}, sprite_count, 0);
        chk({tag, "_spr0"}, sprite0_in_line, 0);
        chk({tag, "_ovf"}, sprite_overflow, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sl, yv;
        bit         sz, clr;
        int         p, dup;

        for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
        for (int i = 0; i < 32; i++) secm[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // empty OAM
        run_eval(8'd40, 1'b0, 1'b0, 0);

        // single sprite at entry 0
        oam[0] = 8'h1E; oam[1] = 8'h12; oam[2] = 8'h41; oam[3] = 8'h80;
        run_eval(8'd35, 1'b0, 1'b0, 0);

        // row 8: outside 8x8, inside 8x16
        run_eval(8'd38, 1'b0, 1'b0, 0);
        run_eval(8'd38, 1'b1, 1'b0, 0);

        // ten sprites on one line, eval_start repeated in DONE
        for (int n = 0; n < 10; n++) begin
            oam[4*n] = 8'd10; oam[4*n+1] = 8'(n); oam[4*n+2] = 8'(8'h20 + n); oam[4*n+3] = 8'(8'h40 + n);
        end
        run_eval(8'd12, 1'b0, 1'b0, -1);
        repeat (3) @(negedge clk);
        chk("start_in_done_ignored", busy, 0);

        // clear alone
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        ovf_model = 1'b0;
        chk("ovf_clr_alone", sprite_overflow, 0);

        // clear coinciding with detection
        run_eval(8'd12, 1'b0, 1'b1, 0);
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        ovf_model = 1'b0;
        chk("ovf_clr_after_set", sprite_overflow, 0);

        // exactly eight: worst-case latency
        oam[32] = 8'hFF; oam[36] = 8'hFF;
        run_eval(8'd12, 1'b0, 1'b0, 0);

        // reset during COPY2
        for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
        oam[0] = 8'd20; oam[1] = 8'hAA; oam[2] = 8'hBB; oam[3] = 8'hCC;
        @(negedge clk);
        scanline = 8'd25; sprite_size = 1'b0; eval_start = 1'b1;
        @(negedge clk);
        eval_start = 1'b0;
        repeat (35) @(negedge clk);
        chk("copy2_sec_addr", sec_addr, 2);
        chk("copy2_sec_dout", sec_dout, 8'hBB);
        chk("copy2_oam_addr", oam_addr, 3);
        #1 rst = 1'b1;
        #1 check_all_zero("async_reset");
        ovf_model = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_eval(8'd25, 1'b0, 1'b0, 0);

        // randomized lines
        for (int t = 0; t < 20; t++) begin
            sl = 8'($urandom_range(0, 255));
            sz = 1'($urandom_range(0, 1));
            p = $urandom_range(0, 60);
            for (int i = 0; i < 256; i++) oam[i] = 8'($urandom);
            for (int n = 0; n < 64; n++) begin
                if ($urandom_range(0, 99) < p) begin
                    yv = sl - 8'($urandom_range(0, 17));
                    oam[4*n] = yv;
                end
            end
            dup = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 35) : 0;
            clr = ($urandom_range(0, 3) == 0);
            run_eval(sl, sz, clr, dup);
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
